// File: rtl/avg_pool_stream_if.sv
// Streaming interface between the convolver, the 2x2 average-pooling stage
// and whatever consumes the pooled pixels. The master drives pixels in and
// receives pooled results; the slave (the pooling stage) does the opposite.
interface avg_pool_stream_if;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic               done;

    // Upstream / testbench side: supplies pixels, observes results.
    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data,
        input  done
    );

    // Pooling stage side: consumes pixels, produces results.
    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data,
        output done
    );
endinterface

// File: rtl/avg_pool_stream.sv
// Streaming 2x2 average pooling, stride 2, over an M x M raster-order map.
// Only a half-row of partial sums (one per output column) plus a single held
// pixel are stored; the full feature map never is. Each pooled output is the
// floor of the window sum divided by four.
module avg_pool_stream #(
    parameter int M = 6
) (
    input  logic               clk,
    input  logic               reset,
    avg_pool_stream_if.slave   bus
);

    localparam int CW  = (M > 1) ? $clog2(M) : 1;
    localparam int LBN = M / 2;
    localparam int LW  = (LBN > 1) ? $clog2(LBN) : 1;

    logic [CW-1:0]      row_q, row_d;
    logic [CW-1:0]      col_q, col_d;
    logic signed [17:0] hold_q, hold_d;
    logic signed [17:0] lineBuf_q [LBN];
    logic signed [17:0] lineBuf_d [LBN];
    logic               outValid_q, outValid_d;
    logic signed [15:0] outData_q, outData_d;
    logic               done_q, done_d;

    logic               accept;
    logic               lastCol;
    logic               lastRow;
    logic [LW-1:0]      lbIdx;
    logic signed [17:0] pixExt;
    logic signed [17:0] winSum;

    // Shared decode: whether this cycle's pixel is taken, where it lands in
    // the line buffer, and the full window sum should it complete a window.
    // Once the frame is finished, further pixels are ignored until reset.
    always_comb begin
        accept  = bus.in_valid && !done_q;
        lastCol = (col_q == CW'(M - 1));
        lastRow = (row_q == CW'(M - 1));
        lbIdx   = LW'(col_q >> 1);
        pixExt  = {{2{bus.in_data[15]}}, bus.in_data};
        winSum  = lineBuf_q[lbIdx] + hold_q + pixExt;
    end

    // Raster position tracking: column advances per accepted pixel and wraps
    // into the next row; gaps in in_valid simply freeze the position.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (accept) begin
            if (lastCol) begin
                col_d = '0;
                row_d = lastRow ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Accumulation: even columns park the pixel in hold, odd columns on an
    // even row fold the horizontal pair into the line buffer, and odd columns
    // on an odd row complete the window and emit floor(sum/4). The 18-bit
    // sum of four 16-bit values cannot overflow, and the arithmetic shift
    // result always fits back into 16 bits.
    always_comb begin
        hold_d     = hold_q;
        lineBuf_d  = lineBuf_q;
        outValid_d = 1'b0;
        outData_d  = outData_q;
        done_d     = done_q;
        if (accept) begin
            if (!col_q[0]) begin
                hold_d = pixExt;
            end else if (!row_q[0]) begin
                lineBuf_d[lbIdx] = hold_q + pixExt;
            end else begin
                outValid_d = 1'b1;
                outData_d  = 16'(winSum >>> 2);
                if (lastRow && lastCol) begin
                    done_d = 1'b1;
                end
            end
        end
    end

    // State registers. Reset wipes every partial sum so a frame interrupted
    // mid-way cannot leak into the next one; a pixel presented alongside
    // reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q      <= '0;
            col_q      <= '0;
            hold_q     <= '0;
            for (int i = 0; i < LBN; i++) begin
                lineBuf_q[i] <= '0;
            end
            outValid_q <= 1'b0;
            outData_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            hold_q     <= hold_d;
            lineBuf_q  <= lineBuf_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            done_q     <= done_d;
        end
    end

    // Registered outputs onto the interface.
    assign bus.out_valid = outValid_q;
    assign bus.out_data  = outData_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_avg_pool_stream.sv
// Testbench for avg_pool_stream. A frame-level model stores the pixels it
// has sent and, whenever a 2x2 window is complete, computes its floored
// average directly from the four stored pixels; a per-cycle compare process
// checks out_valid, out_data and done against that model, and literal tables
// pin the model's results for the directed frames.
module tb_avg_pool_stream;

    localparam int M    = 6;
    localparam int NPIX = M * M;

    logic clk = 1'b0;
    logic reset;

    avg_pool_stream_if bus ();

    avg_pool_stream #(.M(M)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 1'b0;

    logic               expValid;
    logic signed [15:0] expData;
    logic               expDone;

    int pix [M][M];
    int idx;
    bit modelDone;

    logic signed [15:0] outQ [$];

    int rampExp [9] = '{3, 5, 7, 15, 17, 19, 27, 29, 31};

    // Floor division by four for signed sums.
    function automatic int floorDiv4(input int s);
        if (s >= 0) return s / 4;
        return -((-s + 3) / 4);
    endfunction

    // Pixel value for raster index i of each directed frame kind.
    function automatic int pixVal(input int kind, input int i);
        case (kind)
            0: return 4;
            1: return i;
            2: begin
                case (i)
                    0: return -1;
                    1: return -2;
                    6: return -3;
                    7: return -4;
                    2: return 1;
                    3: return 1;
                    8: return 1;
                    default: return 0;
                endcase
            end
            3: return 32767;
            default: return -32768;
        endcase
    endfunction

    // Drive one cycle of inputs (called just after a rising edge), predict
    // what the outputs must show after the next edge, then step past it.
    task automatic applyStimulus(input bit rst, input bit v, input int d);
        logic               nV;
        logic signed [15:0] nData;
        logic               nDone;
        int r, c;
        reset        = rst;
        bus.in_valid = v;
        bus.in_data  = 16'(d);
        if (rst) begin
            idx       = 0;
            modelDone = 1'b0;
            nV        = 1'b0;
            nData     = '0;
            nDone     = 1'b0;
        end else begin
            nV    = 1'b0;
            nData = expData;
            if (v && !modelDone) begin
                r = idx / M;
                c = idx % M;
                pix[r][c] = d;
                idx++;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    nV    = 1'b1;
                    nData = 16'(floorDiv4(pix[r-1][c-1] + pix[r-1][c] +
                                          pix[r][c-1] + pix[r][c]));
                end
                if (idx == NPIX) modelDone = 1'b1;
            end
            nDone = modelDone;
        end
        @(posedge clk);
        #1;
        expValid = nV;
        expData  = nData;
        expDone  = nDone;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic checkOutput();
        vectors++;
        if (bus.out_valid !== expValid) begin
            miscompares++;
            $display("[TB] FAIL out_valid at %0t: got %b expected %b", $time, bus.out_valid, expValid);
        end
        vectors++;
        if (bus.done !== expDone) begin
            miscompares++;
            $display("[TB] FAIL done at %0t: got %b expected %b", $time, bus.done, expDone);
        end
        vectors++;
        if (bus.out_data !== expData) begin
            miscompares++;
            $display("[TB] FAIL out_data at %0t: got %0d expected %0d", $time, bus.out_data, expData);
        end
        if (bus.out_valid === 1'b1) outQ.push_back(bus.out_data);
    endtask

    // Hand-computed expectation check.
    task automatic checkLiteral(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outAt(input int i);
        if (i < outQ.size()) return int'(outQ[i]);
        return 32'h7fff_ffff;
    endfunction

    // Sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 0);
    endtask

    // Send a full frame, optionally with random idle gaps, then idle twice
    // so the final pulse has been sampled.
    task automatic runFrame(input int kind, input bit gaps);
        outQ.delete();
        for (int i = 0; i < NPIX; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b0, 0);
            end
            applyStimulus(1'b0, 1'b1, pixVal(kind, i));
        end
        applyStimulus(1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0);
    endtask

    // Directed sequence of frames.
    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        expValid     = 1'b0;
        expData      = '0;
        expDone      = 1'b0;
        idx          = 0;
        modelDone    = 1'b0;
        @(posedge clk);
        #1;
        doReset();
        checkEn = 1'b1;

        $display("[TB] constant frame of 4s");
        runFrame(0, 1'b0);
        checkLiteral("const_count", outQ.size(), 9);
        for (int i = 0; i < 9; i++) checkLiteral("const_value", outAt(i), 4);
        checkLiteral("const_done", int'(bus.done), 1);

        $display("[TB] ramp frame");
        doReset();
        runFrame(1, 1'b0);
        checkLiteral("ramp_count", outQ.size(), 9);
        for (int i = 0; i < 9; i++) checkLiteral("ramp_value", outAt(i), rampExp[i]);

        $display("[TB] negative and rounding windows");
        doReset();
        runFrame(2, 1'b0);
        checkLiteral("neg_floor", outAt(0), -3);
        checkLiteral("small_floor", outAt(1), 0);

        $display("[TB] extremes");
        doReset();
        runFrame(3, 1'b0);
        checkLiteral("max_first", outAt(0), 32767);
        checkLiteral("max_last", outAt(8), 32767);
        doReset();
        runFrame(4, 1'b0);
        checkLiteral("min_first", outAt(0), -32768);
        checkLiteral("min_last", outAt(8), -32768);

        $display("[TB] ramp with gaps, then inputs after done");
        doReset();
        runFrame(1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 100 + i);
        applyStimulus(1'b0, 1'b0, 0);
        checkLiteral("gap_count", outQ.size(), 9);
        for (int i = 0; i < 9; i++) checkLiteral("gap_value", outAt(i), rampExp[i]);
        checkLiteral("gap_done_sticky", int'(bus.done), 1);

        $display("[TB] reset mid-frame");
        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, i);
        applyStimulus(1'b1, 1'b1, 99);
        runFrame(0, 1'b0);
        checkLiteral("midreset_count", outQ.size(), 9);
        for (int i = 0; i < 9; i++) checkLiteral("midreset_value", outAt(i), 4);

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/avg_pool_stream.md
Name: avg_pool_stream

Overview:
- Streaming 2x2 average-pooling stage placed directly downstream of the clocked image convolver.
- Consumes one signed 16-bit convolved pixel per valid cycle, in raster order (row-major, left to right, top to bottom) over an M x M feature map.
- Emits one pooled pixel per non-overlapping 2x2 window, stride 2, producing (M/2) x (M/2) outputs in raster order.
- Holds a half-row line buffer of partial sums, so the full feature map is never stored.

Parameters:
- M, 6, feature-map width and height (convolver n-4). Must be even and >= 2; an odd M is a configuration error, with no runtime check.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data carries the next raster-order pixel this cycle.
- in_data  input  16  signed convolved pixel.
- out_valid  output  1  single-cycle pulse; out_data is valid.
- out_data  output  16  signed pooled pixel.
- done  output  1  sticky; all (M/2)^2 outputs have been produced.

Behaviour:
- Reset (sync, high) at a clock edge, taking priority over all other activity:
  - row, col, the held-pixel register and all line-buffer entries cleared to 0.
  - out_valid=0, out_data=0, done=0.
  - Reset mid-frame discards all partial sums; the next valid input is treated as pixel (0,0).
- Counters:
  - col 0..M-1 and row 0..M-1 advance only on cycles with in_valid=1 and done=0.
  - col wraps to 0 after M-1 and increments row at that point.
- Storage and arithmetic, per accepted pixel p at (row, col):
  - Even row, even col: hold <= p (sign-extended to 18 bits).
  - Even row, odd col: lb[col/2] <= hold + p (18-bit signed).
  - Odd row, even col: hold <= p.
  - Odd row, odd col: sum = lb[col/2] + hold + p (18-bit signed, no overflow possible).
    - out_data <= sum >>> 2 (arithmetic shift, i.e. floor division by 4), bits [17:2], which always fits in 16 bits.
    - out_valid <= 1.
- Latency: out_valid rises on the clock edge after the edge accepting the window's bottom-right pixel (1 cycle). It is low on every other cycle.
- out_data holds its last value when out_valid=0.
- Gaps: in_valid may drop for any number of cycles at any point; state is held and the result is identical to a gapless stream.
- done:
  - Set on the same edge that produces the final out_valid, i.e. after pixel (M-1, M-1) is accepted.
  - Stays 1 until reset.
  - While done=1, in_valid is ignored: no counter movement and no further out_valid.
- No backpressure. The downstream stage must accept every out_valid pulse.
- Throughput: one input per cycle sustained; at most one output per two inputs.

Test Plan:
- Reset, then 36 inputs all equal to 4, in_valid held high → 9 out_valid pulses, each with out_data=4. The first pulse comes on the cycle after input #8, i.e. (1,1). done rises with the 9th pulse.
- Ramp input 0..35 in raster order → outputs 3, 5, 7, 15, 17, 19, 27, 29, 31.
  - Example: the first window (0, 1, 6, 7) sums to 14, and 14>>>2 = 3.
- Window (-1, -2, -3, -4) with all other pixels 0 → first output -3 (floor of -2.5). Window (1, 1, 1, 0) → 0.
- Extremes: all pixels 32767 → every output 32767. All pixels -32768 → every output -32768.
- Ramp stream with random in_valid gaps of 0-3 cycles → same 9 values as the gapless ramp, each 1 cycle after its completing input. After done, 5 extra valid inputs → no out_valid, done stays 1.
- Assert reset after 20 ramp inputs, then send a fresh full stream of 4s → exactly 9 outputs of 4, with no stale partial sums. A reset with in_valid=1 in the same cycle drops that pixel.
